alu_mul_sequencer: RTL and testbench

//  Iterative 32x32->32 MUL/MLA controller in the EXE stage. It sequences the

---
 rtl/alu_mul_sequencer_pkg.sv | 21 ++
 rtl/alu_mul_sequencer.sv | 128 ++++++++++++
 tb/tb_alu_mul_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/alu_mul_sequencer_pkg.sv
// Shared EXE-stage definitions: ALU command encodings and multiply-sequencer state encoding.
package alu_mul_sequencer_pkg;

  localparam int EXE_WIDTH = 32;
  localparam int EXE_CMD_W = 4;

  localparam logic [EXE_CMD_W-1:0] EXE_CMD_MOV = 4'b0001;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_MVN = 4'b1001;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_ADD = 4'b0010;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_ADC = 4'b0011;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_SUB = 4'b0100;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_SBC = 4'b0101;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_AND = 4'b0110;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_ORR = 4'b0111;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_EOR = 4'b1000;

  localparam logic [1:0] MUL_ST_IDLE = 2'd0;
  localparam logic [1:0] MUL_ST_ITER = 2'd1;
  localparam logic [1:0] MUL_ST_DONE = 2'd2;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Iterative MUL/MLA controller: borrows the EXE-stage ALU for one shift-and-add
// step per cycle, stalls the pipeline meanwhile and reports N/Z on completion.
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int                 WIDTH   = EXE_WIDTH,
  parameter int                 CMD_W   = EXE_CMD_W,
  parameter logic [CMD_W-1:0]   CMD_ADD = EXE_CMD_ADD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             acc_en,
  input  logic             set_flags,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] exe_val1,
  input  logic [WIDTH-1:0] exe_val2,
  input  logic [CMD_W-1:0] exe_cmd,
  input  logic             exe_c,
  output logic [WIDTH-1:0] alu_val1,
  output logic [WIDTH-1:0] alu_val2,
  output logic [CMD_W-1:0] alu_cmd,
  output logic             alu_c,
  input  logic [WIDTH-1:0] alu_res,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_we,
  output logic             flag_n,
  output logic             flag_z
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             flag_n_q, flag_n_d;
  logic             flag_z_q, flag_z_d;
  logic [WIDTH-1:0] mplier_shr;

  assign mplier_shr = mplier_q >> 1;

  // Result and flags are captured on the transition into DONE so they come straight from flops.
  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
    flag_n_d = flag_n_q;
    flag_z_d = flag_z_q;
    case (state_q)
      MUL_ST_IDLE: begin
        if (start) begin
          sum_d    = acc_en ? acc : '0;
          mcand_d  = op_a;
          mplier_d = op_b;
          if (op_b == '0) begin
            state_d  = MUL_ST_DONE;
            result_d = sum_d;
            flag_n_d = sum_d[WIDTH-1];
            flag_z_d = (sum_d == '0);
          end else begin
            state_d = MUL_ST_ITER;
          end
        end
      end
      MUL_ST_ITER: begin
        sum_d    = alu_res;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_shr;
        if (mplier_shr == '0) begin
          state_d  = MUL_ST_DONE;
          result_d = alu_res;
          flag_n_d = alu_res[WIDTH-1];
          flag_z_d = (alu_res == '0);
        end
      end
      MUL_ST_DONE: state_d = MUL_ST_IDLE;
      default:     state_d = MUL_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MUL_ST_IDLE;
      sum_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
      flag_n_q <= flag_n_d;
      flag_z_q <= flag_z_d;
    end
  end

  // The sequencer owns the ALU only while iterating; otherwise the normal EXE path drives it.
  always_comb begin
    alu_val1 = exe_val1;
    alu_val2 = exe_val2;
    alu_cmd  = exe_cmd;
    alu_c    = exe_c;
    if (state_q == MUL_ST_ITER) begin
      alu_val1 = sum_q;
      alu_val2 = mplier_q[0] ? mcand_q : '0;
      alu_cmd  = CMD_ADD;
      alu_c    = 1'b0;
    end
  end

  assign busy    = ((state_q == MUL_ST_IDLE) && start) || (state_q == MUL_ST_ITER);
  assign done    = (state_q == MUL_ST_DONE);
  assign flag_we = done && set_flags;
  assign result  = result_q;
  assign flag_n  = flag_n_q;
  assign flag_z  = flag_z_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed scoreboard bench for alu_mul_sequencer with a small behavioural ALU attached.
module tb_alu_mul_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        acc_en;
  logic        set_flags;
  logic [31:0] op_a, op_b, acc;
  logic [31:0] exe_val1, exe_val2;
  logic [3:0]  exe_cmd;
  logic        exe_c;
  logic [31:0] alu_val1, alu_val2;
  logic [3:0]  alu_cmd;
  logic        alu_c;
  logic [31:0] alu_res;
  logic        busy, done, flag_we, flag_n, flag_z;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    logic        we;
    logic        n;
    logic        z;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;

  alu_mul_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .acc_en(acc_en), .set_flags(set_flags),
    .op_a(op_a), .op_b(op_b), .acc(acc),
    .exe_val1(exe_val1), .exe_val2(exe_val2), .exe_cmd(exe_cmd), .exe_c(exe_c),
    .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_cmd(alu_cmd), .alu_c(alu_c),
    .alu_res(alu_res), .busy(busy), .done(done), .result(result),
    .flag_we(flag_we), .flag_n(flag_n), .flag_z(flag_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the EXE-stage ALU.
  always_comb begin
    case (alu_cmd)
      4'b0010: alu_res = alu_val1 + alu_val2;
      4'b0011: alu_res = alu_val1 + alu_val2 + {31'b0, alu_c};
      4'b0100: alu_res = alu_val1 - alu_val2;
      default: alu_res = alu_val2;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Issues one request at posedge+1 and queues its hand-computed outcome; k is the iteration count.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [31:0] accv,
                               input logic ae, input logic sf, input logic [31:0] exp_res, input int k);
    exp_t e;
    e.res = exp_res;
    e.we  = sf;
    e.n   = exp_res[31];
    e.z   = (exp_res == 32'h0);
    e.due = cyc + 1 + k;
    sb.push_back(e);
    op_a = a; op_b = b; acc = accv; acc_en = ae; set_flags = sf;
    start = 1'b1;
    @(negedge clk);
    checkOutput("busy_on_issue", {31'b0, busy}, 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitDone();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      $display("[TB] FAIL timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    #1;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_done: got done=1 expected no result pending (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("result",  result, e.res);
        checkOutput("flag_we", {31'b0, flag_we}, {31'b0, e.we});
        checkOutput("flag_n",  {31'b0, flag_n},  {31'b0, e.n});
        checkOutput("flag_z",  {31'b0, flag_z},  {31'b0, e.z});
        checkOutput("busy_in_done", {31'b0, busy}, 32'd0);
        checkOutput("latency", cyc, e.due);
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; acc_en = 1'b0; set_flags = 1'b0;
    op_a = '0; op_b = '0; acc = '0;
    exe_val1 = 32'd5; exe_val2 = 32'd7; exe_cmd = 4'b0100; exe_c = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    checkOutput("rst_busy",    {31'b0, busy},    32'd0);
    checkOutput("rst_done",    {31'b0, done},    32'd0);
    checkOutput("rst_flag_we", {31'b0, flag_we}, 32'd0);
    checkOutput("rst_flag_n",  {31'b0, flag_n},  32'd0);
    checkOutput("rst_flag_z",  {31'b0, flag_z},  32'd0);
    checkOutput("rst_result",  result,           32'd0);
    checkOutput("pass_val1",   alu_val1,         32'd5);
    checkOutput("pass_val2",   alu_val2,         32'd7);
    checkOutput("pass_cmd",    {28'b0, alu_cmd}, 32'h4);
    checkOutput("pass_c",      {31'b0, alu_c},   32'd1);
    @(posedge clk);
    #1;

    applyStimulus(32'd3, 32'd5, 32'd0, 1'b0, 1'b1, 32'd15, 3);
    waitDone();

    applyStimulus(32'd7, 32'd0, 32'd9, 1'b1, 1'b0, 32'd9, 0);
    waitDone();

    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1, 32'h00000001, 32);
    @(negedge clk);
    checkOutput("iter_busy", {31'b0, busy},    32'd1);
    checkOutput("iter_cmd",  {28'b0, alu_cmd}, 32'h2);
    checkOutput("iter_c",    {31'b0, alu_c},   32'd0);
    checkOutput("iter_val1", alu_val1,         32'h0);
    checkOutput("iter_val2", alu_val2,         32'hFFFFFFFF);
    checkOutput("iter_done", {31'b0, done},    32'd0);
    waitDone();

    applyStimulus(32'h80000000, 32'd2, 32'd0, 1'b0, 1'b1, 32'h00000000, 2);
    waitDone();
    applyStimulus(32'h40000000, 32'd2, 32'd0, 1'b0, 1'b1, 32'h80000000, 2);
    waitDone();

    applyStimulus(32'd6, 32'd7, 32'd100, 1'b1, 1'b0, 32'd142, 3);
    waitDone();

    // Abort a 13*13 in its second iteration; no result may appear.
    op_a = 32'd13; op_b = 32'd13; acc_en = 1'b0; set_flags = 1'b1;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy",    {31'b0, busy},    32'd0);
    checkOutput("abort_done",    {31'b0, done},    32'd0);
    checkOutput("abort_flag_we", {31'b0, flag_we}, 32'd0);
    checkOutput("abort_result",  result,           32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("abort_no_done", {31'b0, done}, 32'd0);
    end
    @(posedge clk);
    #1;

    applyStimulus(32'd5, 32'd5, 32'd0, 1'b0, 1'b0, 32'd25, 3);
    waitDone();

    repeat (3) @(posedge clk);
    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
